// File: rtl/wchb_sync_sink_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wchb_sync_sink_if
//  Description : Bundle of the signals of wchb_sync_sink. It carries the
//                4-phase return-to-zero request/acknowledge pair with its
//                bundled data (async side) and the valid/ready FIFO output
//                (sync side).
//  Ports       : i_req, i_data, o_ack   -- async 4-phase bundled-data side
//                o_valid, i_ready,
//                o_data, o_level        -- synchronous valid/ready side
//  Modports    : slave  -- the sink itself (i_* are inputs, o_* are outputs)
//                master -- the environment driving the sink
//  Revision    : 1.0  initial release
// ============================================================================
interface wchb_sync_sink_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic                       i_req;
    logic [WIDTH-1:0]           i_data;
    logic                       o_ack;
    logic                       o_valid;
    logic                       i_ready;
    logic [WIDTH-1:0]           o_data;
    logic [$clog2(DEPTH+1)-1:0] o_level;

    modport slave (
        input  i_req,
        input  i_data,
        input  i_ready,
        output o_ack,
        output o_valid,
        output o_data,
        output o_level
    );

    modport master (
        output i_req,
        output i_data,
        output i_ready,
        input  o_ack,
        input  o_valid,
        input  o_data,
        input  o_level
    );
endinterface
`default_nettype wire

// File: rtl/wchb_sync_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wchb_sync_sink
//  Description : Synchronous receiver at the output end of an asynchronous
//                WCHB pipeline. The request is synchronised into clk. Each
//                4-phase token is captured into a DEPTH-entry FIFO and then
//                presented on a valid/ready interface.
//  Ports       : clk  -- clock, all state changes on the rising edge
//                rst  -- synchronous active-high reset
//                bus  -- wchb_sync_sink_if.slave:
//                        i_req/i_data/o_ack    4-phase bundled-data input
//                        o_valid/i_ready/o_data FIFO head, valid/ready
//                        o_level               FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module wchb_sync_sink #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wchb_sync_sink_if.slave   bus
);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_lvl_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_full = c_lvl_w'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Request synchroniser. Only the last stage is ever looked at.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_req};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Handshake FSM. The token is sampled into a one-entry staging
    // register on the IDLE->ACK edge and written into the FIFO on the
    // next edge, so o_valid rises one edge after o_ack.
    //
    // In IDLE no staged write can still be pending: the write lands one
    // edge after entering ACK, and ACK always lasts longer than that
    // because req_s must first fall. So r_level alone is the full flag.
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_ack;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_wr_data;
    logic [c_lvl_w-1:0] r_level;
    logic             w_full;

    assign w_full = (r_level == c_lvl_full);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // When full, the token stays parked on the async side
                    // until a pop frees an entry.
                    if (w_req_s && !w_full) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= bus.i_data;
                        r_ack     <= 1'b1;
                        r_state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO. The pointers wrap naturally because DEPTH is a power of two.
    // The occupancy is kept as a separate counter.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               w_valid;
    logic               w_pop;

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & bus.i_ready;

    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_mem[r_wr_ptr] <= r_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (r_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case ({r_wr_en, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.o_ack   = r_ack;
    assign bus.o_valid = w_valid;
    assign bus.o_data  = r_mem[r_rd_ptr];
    assign bus.o_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_wchb_sync_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wchb_sync_sink
//  Description : Self-checking bench for wchb_sync_sink. A behavioural
//                4-phase sender drives tokens and a random consumer pops
//                them. Expected data comes from a queue of acknowledged
//                tokens, and handshake latencies come from the stage count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wchb_sync_sink;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wchb_sync_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    wchb_sync_sink #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               n_total = 0;
    int               n_bad   = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               ready_mode;   // 0: never ready, 1: always, 2: random
    bit               watch_level;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle. Outputs and inputs are stable here, so a pop that
    // will happen on the coming edge is scored before the edge.
    task automatic tick();
        logic [WIDTH-1:0] head;
        if (!rst && bus.o_valid && bus.i_ready) begin
            check_eq("pop_has_expected_token", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                head = exp_q.pop_front();
                check_eq("pop_data_order", 64'(bus.o_data), 64'(head));
            end
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.i_ready = 1'b0;
            1:       bus.i_ready = 1'b1;
            default: bus.i_ready = 1'($urandom_range(0, 1));
        endcase
        if (watch_level) begin
            check_eq("level_within_depth", 64'(bus.o_level <= 2'(DEPTH)), 64'd1);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n;
        n = 0;
        while (bus.o_ack !== lvl && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(bus.o_ack), 64'(lvl));
    endtask

    task automatic send_token(input logic [WIDTH-1:0] data);
        bus.i_data = data;
        bus.i_req  = 1'b1;
        wait_ack(1'b1, "send_ack_rise");
        exp_q.push_back(data);
        bus.i_data = $urandom;     // legal once acknowledged
        bus.i_req  = 1'b0;
        wait_ack(1'b0, "send_ack_fall");
    endtask

    task automatic drain();
        int n;
        ready_mode = 1;
        bus.i_ready = 1'b1;
        n = 0;
        while (bus.o_level != 0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("drain_level_zero", 64'(bus.o_level), 64'd0);
        check_eq("drain_model_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        ready_mode  = 0;
        watch_level = 1'b0;
        repeat (3) tick();
        check_eq("reset_ack", 64'(bus.o_ack), 64'd0);
        check_eq("reset_valid", 64'(bus.o_valid), 64'd0);
        check_eq("reset_level", 64'(bus.o_level), 64'd0);
        rst = 1'b0;
        tick();

        // T1: single token with exact handshake latencies
        bus.i_data = 32'hDEADBEEF;
        bus.i_req  = 1'b1;
        repeat (SYNC) tick();
        check_eq("t1_ack_not_early", 64'(bus.o_ack), 64'd0);
        tick();
        check_eq("t1_ack_rise_latency", 64'(bus.o_ack), 64'd1);
        check_eq("t1_valid_not_with_ack", 64'(bus.o_valid), 64'd0);
        exp_q.push_back(32'hDEADBEEF);
        tick();
        check_eq("t1_valid_next_edge", 64'(bus.o_valid), 64'd1);
        check_eq("t1_data", 64'(bus.o_data), 64'hDEADBEEF);
        check_eq("t1_level", 64'(bus.o_level), 64'd1);
        bus.i_req = 1'b0;
        repeat (SYNC) tick();
        check_eq("t1_ack_fall_not_early", 64'(bus.o_ack), 64'd1);
        tick();
        check_eq("t1_ack_fall_latency", 64'(bus.o_ack), 64'd0);
        drain();

        // T2 + T4: back-pressure, then pop while full with req pending
        ready_mode = 0;
        send_token(32'hA1A1A1A1);
        send_token(32'hA2A2A2A2);
        check_eq("t2_level_full", 64'(bus.o_level), 64'd2);
        check_eq("t2_head_a1", 64'(bus.o_data), 64'hA1A1A1A1);
        bus.i_data = 32'hA3A3A3A3;
        bus.i_req  = 1'b1;
        repeat (8) tick();
        check_eq("t2_a3_held_off", 64'(bus.o_ack), 64'd0);
        check_eq("t2_level_still_full", 64'(bus.o_level), 64'd2);
        bus.i_ready = 1'b1;
        tick();
        check_eq("t4_pop_no_push_level", 64'(bus.o_level), 64'd1);
        check_eq("t4_pop_no_push_ack", 64'(bus.o_ack), 64'd0);
        tick();
        check_eq("t4_push_next_edge", 64'(bus.o_ack), 64'd1);
        exp_q.push_back(32'hA3A3A3A3);
        tick();
        check_eq("t4_level_back_full", 64'(bus.o_level), 64'd2);
        bus.i_req = 1'b0;
        wait_ack(1'b0, "t2_a3_ack_fall");
        drain();

        // T3: streaming, always-ready then random-ready consumer
        watch_level = 1'b1;
        ready_mode  = 1;
        for (int i = 0; i < 20; i++) send_token($urandom);
        ready_mode = 2;
        for (int i = 0; i < 20; i++) send_token($urandom);
        drain();
        watch_level = 1'b0;

        // T5: long request, data churns after the ack
        ready_mode = 1;
        bus.i_data = $urandom;
        bus.i_req  = 1'b1;
        wait_ack(1'b1, "t5_ack_rise");
        exp_q.push_back(bus.i_data);
        for (int i = 0; i < 50; i++) begin
            bus.i_data = $urandom;
            tick();
            check_eq("t5_ack_held", 64'(bus.o_ack), 64'd1);
        end
        bus.i_req = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        drain();

        // T6: reset in the middle of the ACK phase
        ready_mode = 0;
        bus.i_data = 32'h0BADF00D;
        bus.i_req  = 1'b1;
        wait_ack(1'b1, "t6_ack_rise");
        exp_q.push_back(32'h0BADF00D);
        tick();
        check_eq("t6_pre_level", 64'(bus.o_level), 64'd1);
        check_eq("t6_pre_ack", 64'(bus.o_ack), 64'd1);
        rst       = 1'b1;
        bus.i_req = 1'b0;
        tick();
        check_eq("t6_ack_cleared", 64'(bus.o_ack), 64'd0);
        check_eq("t6_valid_cleared", 64'(bus.o_valid), 64'd0);
        check_eq("t6_level_cleared", 64'(bus.o_level), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        send_token(32'h12345678);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
